prio_irq_ctrl8: RTL and testbench
=================================

Name: prio_irq_ctrl8

Overview:
- 8-line interrupt request controller built around a priority encoder.
- Captures rising edges on 8 request lines into a pending register and presents the highest-priority pending index as a vector (bit 7 highest).
- Holds the vector stable under a request/acknowledge handshake and clears the serviced bit on acknowledge.
- Its pending register is the encoder's input word, so the block turns raw request pins into a stable, serviceable code for the downstream CPU/sequencer.

Parameters:
- N_REQ, 8, number of request lines; fixed at 8 in this revision.
- VEC_W, 3, vector width, log2(N_REQ).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  grant enable, high = active; gates new grants only.
- req  input  8  raw request lines, rising-edge sensitive.
- ack  input  1  acknowledge from consumer, level.
- irq  output  1  interrupt valid; vec is meaningful while high.
- vec  output  3  index of the granted request.
- any_pend  output  1  pending register non-zero.
- none  output  1  en high and nothing pending.
- mask  input  8  present only with IRQ_MASK_EN; 1 = line masked.

Behaviour:
- Reset is synchronous. On rst=1 at a clock edge:
  - pending=0, irq=0, vec=0, state=IDLE.
  - req_d=8'hFF, so lines already high at reset do not fire.
  - any_pend=0, none=en (combinational).
- Edge detect: rise = req & ~req_d; req_d <= req every cycle.
- Pending update: pending <= (pending & ~clr) | rise. A set wins over a clear on the same bit in the same cycle.
- clr is one-hot of vec, and only in the cycle the SERVE→ACKW transition fires; otherwise 0.
- Encoder: combinational. Highest set bit of pending gives the index; valid = |pending.
- FSM states IDLE, SERVE, ACKW (2-bit encoding):
  - IDLE: if en & |pending, then vec <= encoder index, irq <= 1, go SERVE. Else stay, irq=0.
  - SERVE: vec and irq are held. No preemption: a higher-priority arrival does not change vec. When ack=1: clear pending[vec], irq <= 0, go ACKW. en=0 does not withdraw an active grant.
  - ACKW: wait for ack=0, then go IDLE. ack held high never causes a second clear.
- Latency:
  - req sampled high at edge k sets pending after edge k.
  - irq rises after edge k+1 if IDLE and en.
  - ack sampled at edge m drops irq after edge m.
  - The next grant comes at the earliest 2 edges after ack falls (ACKW→IDLE→SERVE).
- Levels are not re-armed: a line held high generates one request only, and must return low before it can request again.
- any_pend = |pending and none = en & ~|pending, both combinational from registers (the encoder's GS/EO analogues).
- Mid-operation reset: abandons the grant. irq drops after the reset edge and all pending bits are lost.

Optional Feature:
- Macro: IRQ_MASK_EN.
- Defined:
  - The mask port exists.
  - The encoder input is pending & ~mask.
  - Masked bits still latch into pending and still count in any_pend.
  - Unmasking a pending bit makes it eligible on the next IDLE evaluation.
  - A mask change during SERVE does not alter vec.
- Undefined: no mask port; the encoder input is pending.

Decomposition:
- Shared package prio_irq_pkg: N_REQ, VEC_W, state localparams (S_IDLE=2'd0, S_SERVE=2'd1, S_ACKW=2'd2), REQ_D_RST=8'hFF.
- Sub-module prio_enc8: purely combinational 8→3 priority encoder with outputs idx[2:0] and valid, instantiated once. The FSM, edge detect and pending register stay in the top.

Test Plan:
1. Reset handling: hold req=8'hFF through reset, release rst, hold req for 5 cycles → pending=0, irq=0, any_pend=0, none=1 (en=1).
2. Single request: en=1, pulse req[3] for 1 cycle at edge k → irq=1 and vec=3 after edge k+1. Then ack for 1 cycle → irq=0, pending=0, none=1 two cycles later.
3. Simultaneous requests: one-cycle req=8'b1010_0100 edge → served in order vec=7, 5, 2, each after its own ack pulse. any_pend falls after the third ack.
4. No preemption: while serving vec=2, pulse req[7] → vec stays 2 until ack. The next grant is vec=7.
5. Enable gating and set-wins: with en=0 and req[4] edge → any_pend=1, none=0, irq=0 for 10 cycles. Raise en → irq with vec=4. On the ack edge also pulse req[4] → pending[4] stays 1 and is re-served.
6. IRQ_MASK_EN: mask=8'h80, edges on 7 and 1 → vec=1 served first. Clear mask → vec=7 served next.

Source files
------------

// File: rtl/prio_irq_pkg.sv
// prio_irq_pkg: shared sizes, FSM states and reset constants for prio_irq_ctrl8
package prio_irq_pkg;
  localparam int N_REQ = 8;
  localparam int VEC_W = 3;
  localparam logic [N_REQ-1:0] REQ_D_RST = 8'hFF;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_ACKW  = 2'd2
  } state_t;
endpackage

// File: rtl/prio_enc8.sv
// prio_enc8: combinational 8-to-3 priority encoder, bit 7 highest
module prio_enc8
  import prio_irq_pkg::*;
(
  input  logic [N_REQ-1:0] d,
  output logic [VEC_W-1:0] idx,
  output logic             valid
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < N_REQ; i++) idx = d[i] ? VEC_W'(i) : idx;
  end
  assign valid = |d;
endmodule

// File: rtl/prio_irq_ctrl8.sv
// prio_irq_ctrl8: edge-captured 8-line priority interrupt controller with req/ack handshake (IRQ_MASK_EN adds mask port)
module prio_irq_ctrl8
  import prio_irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             ack,
`ifdef IRQ_MASK_EN
  input  logic [N_REQ-1:0] mask,
`endif
  output logic             irq,
  output logic [VEC_W-1:0] vec,
  output logic             any_pend,
  output logic             none
);
  state_t           state_q;
  logic [N_REQ-1:0] req_prev_q;
  logic [N_REQ-1:0] pending_q;
  logic [N_REQ-1:0] pending_d;
  logic [N_REQ-1:0] enc_in;
  logic [VEC_W-1:0] vec_q;
  logic             irq_q;
  logic [VEC_W-1:0] enc_idx;
  logic             enc_valid;
  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] clr;
  assign rise      = req & ~req_prev_q;
  assign clr       = (state_q == S_SERVE && ack) ? N_REQ'(1) << vec_q : '0;
  assign pending_d = (pending_q & ~clr) | rise;
`ifdef IRQ_MASK_EN
  assign enc_in = pending_q & ~mask;
`else
  assign enc_in = pending_q;
`endif
  prio_enc8 u_enc (
    .d     (enc_in),
    .idx   (enc_idx),
    .valid (enc_valid)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_prev_q <= REQ_D_RST;
      pending_q  <= '0;
      vec_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      req_prev_q <= req;
      pending_q  <= pending_d;
      case (state_q)
        S_IDLE: if (en && enc_valid) begin
          vec_q   <= enc_idx;
          irq_q   <= 1'b1;
          state_q <= S_SERVE;
        end
        S_SERVE: if (ack) begin
          irq_q   <= 1'b0;
          state_q <= S_ACKW;
        end
        S_ACKW: if (!ack) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign irq      = irq_q;
  assign vec      = vec_q;
  assign any_pend = |pending_q;
  assign none     = en & ~|pending_q;
endmodule

// File: tb/tb_prio_irq_ctrl8.sv
// tb_prio_irq_ctrl8: directed and random checks of prio_irq_ctrl8 against a behavioural model
module tb_prio_irq_ctrl8;
  logic       clk = 1'b0;
  logic       rst, en, ack;
  logic [7:0] req, mask;
  logic       irq, any_pend, none;
  logic [2:0] vec;
  int         total = 0;
  int         bad = 0;
  logic [7:0] m_pend, m_prev;
  logic       m_irq, m_hold;
  logic [2:0] m_vec;
  int         exp3 [3] = '{7, 5, 2};
  always #5 clk = ~clk;
  prio_irq_ctrl8 dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .ack      (ack),
`ifdef IRQ_MASK_EN
    .mask     (mask),
`endif
    .irq      (irq),
    .vec      (vec),
    .any_pend (any_pend),
    .none     (none)
  );
  function automatic logic [7:0] elig();
`ifdef IRQ_MASK_EN
    return m_pend & ~mask;
`else
    return m_pend;
`endif
  endfunction
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic model();
    logic [7:0] rise, clrm, e;
    rise = req & ~m_prev;
    clrm = '0;
    if (rst) begin
      m_pend = '0;
      m_prev = 8'hFF;
      m_irq  = 1'b0;
      m_vec  = '0;
      m_hold = 1'b0;
      return;
    end
    if (m_irq) begin
      if (ack) begin
        clrm   = 8'(1) << m_vec;
        m_irq  = 1'b0;
        m_hold = 1'b1;
      end
    end else if (m_hold) begin
      if (!ack) m_hold = 1'b0;
    end else if (en) begin
      e = elig();
      for (int i = 7; i >= 0; i--)
        if (e[i] && !m_irq) begin
          m_vec = 3'(i);
          m_irq = 1'b1;
        end
    end
    m_pend = (m_pend & ~clrm) | rise;
    m_prev = req;
  endtask
  task automatic tick();
    @(posedge clk);
    model();
    #1;
    chk("irq", 8'(irq), 8'(m_irq));
    chk("vec", 8'(vec), 8'(m_vec));
    chk("any_pend", 8'(any_pend), 8'(|m_pend));
    chk("none", 8'(none), 8'(en & ~|m_pend));
  endtask
  task automatic ack_pulse();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    tick();
  endtask
  initial begin
    rst = 1'b1; en = 1'b1; ack = 1'b0; req = 8'hFF; mask = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("t1_irq", 8'(irq), 8'd0);
    chk("t1_any", 8'(any_pend), 8'd0);
    chk("t1_none", 8'(none), 8'd1);
    req = 8'h00;
    tick();
    req = 8'h08;
    tick();
    req = 8'h00;
    chk("t2_irq_early", 8'(irq), 8'd0);
    tick();
    chk("t2_irq", 8'(irq), 8'd1);
    chk("t2_vec", 8'(vec), 8'd3);
    ack = 1'b1;
    tick();
    chk("t2_irq_drop", 8'(irq), 8'd0);
    ack = 1'b0;
    tick();
    tick();
    chk("t2_none", 8'(none), 8'd1);
    chk("t2_any", 8'(any_pend), 8'd0);
    req = 8'hA4;
    tick();
    req = 8'h00;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("t3_irq", 8'(irq), 8'd1);
      chk("t3_vec", 8'(vec), 8'(exp3[k]));
      chk("t3_any", 8'(any_pend), 8'd1);
      ack = 1'b1;
      tick();
      if (k == 2) chk("t3_any_last", 8'(any_pend), 8'd0);
      ack = 1'b0;
      tick();
      tick();
    end
    req = 8'h04;
    tick();
    req = 8'h00;
    tick();
    chk("t4_vec_first", 8'(vec), 8'd2);
    req = 8'h80;
    tick();
    req = 8'h00;
    tick();
    tick();
    chk("t4_hold", 8'(vec), 8'd2);
    ack_pulse();
    chk("t4_next", 8'(vec), 8'd7);
    ack_pulse();
    en = 1'b0;
    req = 8'h10;
    tick();
    req = 8'h00;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t5_gated", 8'(irq), 8'd0);
    end
    chk("t5_any", 8'(any_pend), 8'd1);
    chk("t5_none", 8'(none), 8'd0);
    en = 1'b1;
    tick();
    chk("t5_irq", 8'(irq), 8'd1);
    chk("t5_vec", 8'(vec), 8'd4);
    ack = 1'b1;
    req = 8'h10;
    tick();
    ack = 1'b0;
    req = 8'h00;
    chk("t5_setwins", 8'(any_pend), 8'd1);
    tick();
    tick();
    chk("t5_reserve", 8'(irq), 8'd1);
    chk("t5_revec", 8'(vec), 8'd4);
    ack_pulse();
`ifdef IRQ_MASK_EN
    mask = 8'h80;
    req = 8'h82;
    tick();
    req = 8'h00;
    tick();
    chk("t6_masked", 8'(vec), 8'd1);
    mask = 8'h00;
    ack_pulse();
    chk("t6_unmasked", 8'(vec), 8'd7);
    ack_pulse();
`endif
    req = 8'h40;
    tick();
    req = 8'h00;
    tick();
    chk("rst_pre", 8'(irq), 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_irq", 8'(irq), 8'd0);
    chk("rst_any", 8'(any_pend), 8'd0);
    repeat (600) begin
      req  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : req;
      en   = $urandom_range(0, 3) != 0;
      ack  = $urandom_range(0, 2) == 0;
      mask = ($urandom_range(0, 7) == 0) ? 8'($urandom) : mask;
      rst  = $urandom_range(0, 99) == 0;
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
